meas_bank_ctrl: RTL and testbench

Epoch and ping-pong bank controller for the passive flow-measurement path. It owns the choice of which counter BRAM bank the scheduler updates. It swaps banks at each epoch boundary, derived from the time base or from a software force. After each swap it sweeps the retired bank through BRAM port B: it reads every flow counter, clears it, and pushes non-zero counters to the DMA report FIFO, honouring FIFO back-pressure.

---
 rtl/meas_bank_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_meas_bank_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_bank_ctrl.sv
// Epoch/ping-pong bank controller: swaps the scheduler's counter bank on epoch
// boundaries and sweeps the retired bank (read, clear, report non-zero) via port B.
module meas_bank_ctrl #(
   parameter int C_ID_WIDTH      = 12,
   parameter int C_COUNTER_WIDTH = 20,
   parameter int C_DRAIN         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_enable,
   input  logic [31:0]                in_time_p,
   input  logic [31:0]                in_epoch_len,
   input  logic                       in_force_swap,
   output logic                       out_active_bank,
   output logic                       out_ram_en1b,
   output logic                       out_ram_we1b,
   output logic [C_ID_WIDTH-1:0]      out_ram_addr1b,
   output logic [C_COUNTER_WIDTH-1:0] out_ram_din1b,
   input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout1b,
   output logic                       out_ram_en2b,
   output logic                       out_ram_we2b,
   output logic [C_ID_WIDTH-1:0]      out_ram_addr2b,
   output logic [C_COUNTER_WIDTH-1:0] out_ram_din2b,
   input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout2b,
   input  logic                       in_dma_fifo_full,
   output logic                       out_dma_fifo_valid,
   output logic [C_ID_WIDTH-1:0]      out_dma_fifo_id,
   output logic [C_COUNTER_WIDTH-1:0] out_dma_fifo_data,
   output logic                       out_busy,
   output logic                       out_sweep_done,
   output logic [15:0]                out_epoch_cnt,
   output logic                       out_overrun
);

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_RD, S_WB, S_HOLD} state_t;

   localparam logic [3:0] DRAIN_LAST = 4'(C_DRAIN - 1);

   state_t                     state;
   logic [3:0]                 drain_cnt;
   logic [31:0]                epoch_start;
   logic                       active_bank;
   logic                       sweep_bank;
   logic                       pending;
   logic                       overrun;
   logic                       busy;
   logic                       sweep_done;
   logic [15:0]                epoch_cnt;
   logic [C_ID_WIDTH-1:0]      hold_id;
   logic [C_COUNTER_WIDTH-1:0] hold_data;

   logic                       ram_en_p0;
   logic                       ram_we_p0;
   logic [C_ID_WIDTH-1:0]      addr_p0;

   logic                       vld_p1;
   logic [C_ID_WIDTH-1:0]      id_p1;
   logic [C_COUNTER_WIDTH-1:0] data_p1;

   logic [31:0]                elapsed;
   logic                       auto_req;
   logic                       swap_req;
   logic [C_COUNTER_WIDTH-1:0] rd_data;
   logic                       rd_nz;
   logic                       wb_stall;
   logic                       hold_go;
   logic                       emit;
   logic                       advance;
   logic                       last_addr;
   logic [C_ID_WIDTH-1:0]      emit_id;
   logic [C_COUNTER_WIDTH-1:0] emit_data;

   // Modulo-2^32 subtraction keeps the epoch timer correct across time-base wrap.
   assign elapsed  = in_time_p - epoch_start;
   assign auto_req = in_enable && (in_epoch_len != 32'd0) && (elapsed >= in_epoch_len);
   assign swap_req = auto_req || in_force_swap || pending;

   assign rd_data   = sweep_bank ? in_ram_dout2b : in_ram_dout1b;
   assign rd_nz     = (rd_data != '0);
   assign wb_stall  = (state == S_WB) && rd_nz && in_dma_fifo_full;
   assign hold_go   = (state == S_HOLD) && !in_dma_fifo_full;
   assign emit      = ((state == S_WB) && rd_nz && !in_dma_fifo_full) || hold_go;
   assign advance   = ((state == S_WB) && !wb_stall) || hold_go;
   assign last_addr = (addr_p0 == '1);
   assign emit_id   = (state == S_HOLD) ? hold_id   : addr_p0;
   assign emit_data = (state == S_HOLD) ? hold_data : rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         drain_cnt   <= 4'd0;
         epoch_start <= in_time_p;
         active_bank <= 1'b0;
         sweep_bank  <= 1'b0;
         pending     <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
         sweep_done  <= 1'b0;
         epoch_cnt   <= 16'd0;
         hold_id     <= '0;
         hold_data   <= '0;
         ram_en_p0   <= 1'b0;
         ram_we_p0   <= 1'b0;
         addr_p0     <= '0;
         vld_p1      <= 1'b0;
         id_p1       <= '0;
         data_p1     <= '0;
      end else begin
         sweep_done <= 1'b0;
         vld_p1     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (swap_req) begin
                  active_bank <= ~active_bank;
                  sweep_bank  <= active_bank;
                  epoch_start <= in_time_p;
                  epoch_cnt   <= epoch_cnt + 16'd1;
                  pending     <= 1'b0;
                  busy        <= 1'b1;
                  drain_cnt   <= 4'd0;
                  state       <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  ram_en_p0 <= 1'b1;
                  ram_we_p0 <= 1'b0;
                  addr_p0   <= '0;
                  state     <= S_RD;
               end else begin
                  drain_cnt <= drain_cnt + 4'd1;
               end
            end
            S_RD: begin
               ram_en_p0 <= 1'b1;
               ram_we_p0 <= 1'b1;
               state     <= S_WB;
            end
            S_WB: begin
               if (wb_stall) begin
                  hold_id   <= addr_p0;
                  hold_data <= rd_data;
                  ram_en_p0 <= 1'b0;
                  ram_we_p0 <= 1'b0;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               ram_en_p0 <= 1'b0;
               ram_we_p0 <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         // Report stage: one-cycle strobe after the WB/HOLD decision
         if (emit) begin
            vld_p1  <= 1'b1;
            id_p1   <= emit_id;
            data_p1 <= emit_data;
         end

         if (advance) begin
            if (last_addr) begin
               ram_en_p0  <= 1'b0;
               ram_we_p0  <= 1'b0;
               busy       <= 1'b0;
               sweep_done <= 1'b1;
               state      <= S_IDLE;
            end else begin
               addr_p0   <= addr_p0 + 1'b1;
               ram_en_p0 <= 1'b1;
               ram_we_p0 <= 1'b0;
               state     <= S_RD;
            end
         end

         // Requests arriving mid-sweep collapse into a single deferred swap.
         if ((state != S_IDLE) && swap_req) begin
            pending <= 1'b1;
            overrun <= 1'b1;
         end
      end
   end

   assign out_active_bank    = active_bank;
   assign out_ram_en1b       = ram_en_p0 && !sweep_bank;
   assign out_ram_we1b       = ram_we_p0 && !sweep_bank;
   assign out_ram_addr1b     = addr_p0;
   assign out_ram_din1b      = '0;
   assign out_ram_en2b       = ram_en_p0 && sweep_bank;
   assign out_ram_we2b       = ram_we_p0 && sweep_bank;
   assign out_ram_addr2b     = addr_p0;
   assign out_ram_din2b      = '0;
   assign out_dma_fifo_valid = vld_p1;
   assign out_dma_fifo_id    = id_p1;
   assign out_dma_fifo_data  = data_p1;
   assign out_busy           = busy;
   assign out_sweep_done     = sweep_done;
   assign out_epoch_cnt      = epoch_cnt;
   assign out_overrun        = overrun;

endmodule

// File: tb/tb_meas_bank_ctrl.sv
// Bench for meas_bank_ctrl: BRAM port-B models, directed epoch/sweep scenarios,
// and a scoreboard queue of expected DMA report words.
module tb_meas_bank_ctrl;

   localparam int IDW   = 12;
   localparam int CW    = 20;
   localparam int DEPTH = 1 << IDW;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [CW-1:0]  data;
   } word_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_enable;
   logic [31:0]    in_time_p;
   logic [31:0]    in_epoch_len;
   logic           in_force_swap;
   logic           out_active_bank;
   logic           out_ram_en1b, out_ram_we1b;
   logic [IDW-1:0] out_ram_addr1b;
   logic [CW-1:0]  out_ram_din1b;
   logic [CW-1:0]  in_ram_dout1b;
   logic           out_ram_en2b, out_ram_we2b;
   logic [IDW-1:0] out_ram_addr2b;
   logic [CW-1:0]  out_ram_din2b;
   logic [CW-1:0]  in_ram_dout2b;
   logic           in_dma_fifo_full;
   logic           out_dma_fifo_valid;
   logic [IDW-1:0] out_dma_fifo_id;
   logic [CW-1:0]  out_dma_fifo_data;
   logic           out_busy;
   logic           out_sweep_done;
   logic [15:0]    out_epoch_cnt;
   logic           out_overrun;

   logic [CW-1:0]  mem1 [DEPTH];
   logic [CW-1:0]  mem2 [DEPTH];
   word_t          exp_q [$];
   int             n_tests = 0;
   int             n_fail  = 0;
   logic           time_run = 1'b0;

   always #5 clk = ~clk;

   meas_bank_ctrl #(.C_ID_WIDTH(IDW), .C_COUNTER_WIDTH(CW), .C_DRAIN(4)) dut (
      .clk(clk), .rst(rst), .in_enable(in_enable), .in_time_p(in_time_p),
      .in_epoch_len(in_epoch_len), .in_force_swap(in_force_swap),
      .out_active_bank(out_active_bank),
      .out_ram_en1b(out_ram_en1b), .out_ram_we1b(out_ram_we1b),
      .out_ram_addr1b(out_ram_addr1b), .out_ram_din1b(out_ram_din1b),
      .in_ram_dout1b(in_ram_dout1b),
      .out_ram_en2b(out_ram_en2b), .out_ram_we2b(out_ram_we2b),
      .out_ram_addr2b(out_ram_addr2b), .out_ram_din2b(out_ram_din2b),
      .in_ram_dout2b(in_ram_dout2b),
      .in_dma_fifo_full(in_dma_fifo_full),
      .out_dma_fifo_valid(out_dma_fifo_valid), .out_dma_fifo_id(out_dma_fifo_id),
      .out_dma_fifo_data(out_dma_fifo_data),
      .out_busy(out_busy), .out_sweep_done(out_sweep_done),
      .out_epoch_cnt(out_epoch_cnt), .out_overrun(out_overrun)
   );

   // Read-first BRAM port B models, one-cycle read latency
   always @(posedge clk) begin
      if (out_ram_en1b) begin
         in_ram_dout1b <= mem1[out_ram_addr1b];
         if (out_ram_we1b) mem1[out_ram_addr1b] = out_ram_din1b;
      end
      if (out_ram_en2b) begin
         in_ram_dout2b <= mem2[out_ram_addr2b];
         if (out_ram_we2b) mem2[out_ram_addr2b] = out_ram_din2b;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every report strobe must match the next queued word.
   always @(negedge clk) begin
      if (!rst && out_dma_fifo_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dma_word", {out_dma_fifo_id, out_dma_fifo_data}, 32'hDEAD);
         end else begin
            word_t w;
            w = exp_q.pop_front();
            check("dma_id", 32'(out_dma_fifo_id), 32'(w.id));
            check("dma_data", 32'(out_dma_fifo_data), 32'(w.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (time_run) in_time_p = in_time_p + 32'd1;
   endtask

   task automatic do_reset(input logic [31:0] t0);
      time_run         = 1'b0;
      in_time_p        = t0;
      in_force_swap    = 1'b0;
      in_dma_fifo_full = 1'b0;
      rst              = 1'b1;
      tick();
      tick();
      rst      = 1'b0;
      time_run = 1'b1;
   endtask

   task automatic force_swap();
      in_force_swap = 1'b1;
      tick();
      in_force_swap = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cycles);
      cycles = 0;
      while (!out_sweep_done && cycles < bound) begin
         tick();
         cycles++;
      end
   endtask

   task automatic wait_swap(input logic target, input int bound, output logic [31:0] t_seen);
      int n;
      n = 0;
      t_seen = 32'hFFFF_FFFF;
      while (out_active_bank !== target && n < bound) begin
         t_seen = in_time_p;
         tick();
         n++;
      end
   endtask

   initial begin
      int          c;
      int          nz;
      logic [31:0] t_seen;
      logic        saw;

      for (int i = 0; i < DEPTH; i++) begin
         mem1[i] = '0;
         mem2[i] = '0;
      end
      rst          = 1'b1;
      in_enable    = 1'b1;
      in_epoch_len = 32'd100;

      // Reset values, then timer-driven swap at time 100
      do_reset(32'd0);
      check("rst_active_bank", 32'(out_active_bank), 0);
      check("rst_epoch_cnt", 32'(out_epoch_cnt), 0);
      check("rst_busy", 32'(out_busy), 0);
      check("rst_overrun", 32'(out_overrun), 0);
      check("rst_ram_en", {out_ram_en1b, out_ram_we1b, out_ram_en2b, out_ram_we2b}, 0);
      check("rst_dma_valid", 32'(out_dma_fifo_valid), 0);

      wait_swap(1'b1, 200, t_seen);
      in_epoch_len = 32'd0;
      check("auto_swap_time", t_seen, 32'd100);
      check("auto_active_bank", 32'(out_active_bank), 1);
      check("auto_epoch_cnt", 32'(out_epoch_cnt), 1);
      check("auto_busy", 32'(out_busy), 1);
      c = 0;
      while (!out_ram_en1b && c < 20) begin
         tick();
         c++;
      end
      check("first_rd_delay", c, 4);
      check("first_rd_addr", 32'(out_ram_addr1b), 0);
      check("first_rd_we", 32'(out_ram_we1b), 0);
      check("first_rd_other_bank", 32'(out_ram_en2b), 0);
      wait_done(9000, nz);
      check("sweep_len", c + nz, 8196);
      tick();
      check("sweep_idle_busy", 32'(out_busy), 0);

      // Preloaded bank with back-pressure at addr 5
      do_reset(32'd0);
      mem1[5]    = 20'h00030;
      mem1[4095] = 20'hFFFFF;
      mem2[7]    = 20'h00123;
      exp_q.push_back('{id: 12'd5,    data: 20'h00030});
      exp_q.push_back('{id: 12'd4095, data: 20'hFFFFF});
      force_swap();
      check("force_active_bank", 32'(out_active_bank), 1);
      check("force_epoch_cnt", 32'(out_epoch_cnt), 1);
      c = 0;
      while (!(out_ram_we1b && out_ram_addr1b == 12'd5) && c < 100) begin
         tick();
         c++;
      end
      check("wb5_reached", 32'(out_ram_we1b && out_ram_addr1b == 12'd5), 1);
      in_dma_fifo_full = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         tick();
         saw = saw | out_dma_fifo_valid;
      end
      check("no_valid_while_full", 32'(saw), 0);
      in_dma_fifo_full = 1'b0;
      tick();
      check("valid_after_full_drop", 32'(out_dma_fifo_valid), 1);
      wait_done(9000, c);
      check("stall_sweep_done", 32'(out_sweep_done), 1);
      tick();
      check("all_words_reported", exp_q.size(), 0);
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem1[i] != '0) nz++;
      check("bram1_cleared", nz, 0);
      check("bram2_untouched", 32'(mem2[7]), 32'h123);
      mem2[7] = '0;

      // Two forced requests mid-sweep collapse into one deferred swap
      do_reset(32'd0);
      force_swap();
      repeat (50) tick();
      force_swap();
      repeat (50) tick();
      force_swap();
      check("overrun_set", 32'(out_overrun), 1);
      check("overrun_epoch_cnt", 32'(out_epoch_cnt), 1);
      wait_done(9000, c);
      check("overrun_sweep_done", 32'(out_sweep_done), 1);
      tick();
      check("pending_swap_bank", 32'(out_active_bank), 0);
      check("pending_swap_cnt", 32'(out_epoch_cnt), 2);
      check("pending_swap_busy", 32'(out_busy), 1);
      wait_done(9000, c);
      repeat (20) tick();
      check("no_third_swap_cnt", 32'(out_epoch_cnt), 2);
      check("no_third_swap_busy", 32'(out_busy), 0);

      // Wrap-correct timer, then reset during RD at addr 100
      in_epoch_len = 32'd10;
      do_reset(32'hFFFF_FFF8);
      wait_swap(1'b1, 50, t_seen);
      in_epoch_len = 32'd0;
      check("wrap_swap_time", t_seen, 32'h0000_0002);
      c = 0;
      while (!(out_ram_en1b && !out_ram_we1b && out_ram_addr1b == 12'd100) && c < 1000) begin
         tick();
         c++;
      end
      check("rd100_reached", 32'(out_ram_en1b && out_ram_addr1b == 12'd100), 1);
      rst = 1'b1;
      tick();
      check("midrst_bank_cnt", {15'd0, out_active_bank, out_epoch_cnt}, 0);
      check("midrst_ram", {out_ram_en1b, out_ram_we1b, out_ram_en2b, out_ram_we2b}, 0);
      check("midrst_addr", 32'(out_ram_addr1b), 0);
      check("midrst_flags", {out_busy, out_sweep_done, out_overrun, out_dma_fifo_valid}, 0);
      rst = 1'b0;
      saw = 1'b0;
      repeat (20) begin
         tick();
         saw = saw | out_ram_en1b | out_ram_en2b;
      end
      check("no_access_after_rst", 32'(saw), 0);

      // Timer disabled: no auto swap, force still honoured
      in_enable    = 1'b0;
      in_epoch_len = 32'd5;
      repeat (20) tick();
      check("disabled_no_swap", 32'(out_active_bank), 0);
      force_swap();
      check("disabled_force_bank", 32'(out_active_bank), 1);
      check("disabled_force_cnt", 32'(out_epoch_cnt), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
